// File: rtl/mem_dump_ctrl.sv
// Debug memory dump controller: reads N_WORDS words from data memory and
// streams each one to a UART transmitter, most-significant byte first.
module mem_dump_ctrl #(
    parameter int unsigned NB_DATA = 32,
    parameter int unsigned NB_ADDR = 10,
    parameter int unsigned N_WORDS = 32,
    parameter int unsigned NB_BYTE = 8
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [NB_DATA-1:0] i_data_mem_debug_unit,
    input  logic               i_tx_done,
    output logic [NB_ADDR-1:0] o_addr_mem_debug_unit,
    output logic               o_ctrl_addr_debug_mem,
    output logic               o_ctrl_wr_debug_mem,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_busy,
    output logic               o_done
);

    localparam int unsigned N_BYTES = NB_DATA / NB_BYTE;
    localparam int unsigned NB_BCNT = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
    localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(N_WORDS - 1);
    localparam logic [NB_BCNT-1:0] LAST_BYTE = NB_BCNT'(N_BYTES - 1);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WAIT_MEM,
        LATCH,
        SEND,
        WAIT_TX,
        NEXT,
        DONE
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [NB_ADDR-1:0]   r_addr;
    logic [NB_DATA-1:0]   r_shift;
    logic [NB_BCNT-1:0]   r_byte_cnt;
    logic                 r_tx_start;
    logic                 r_done;
    logic                 r_busy;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     if (i_start) w_next = ADDR;
            ADDR:     w_next = WAIT_MEM;
            WAIT_MEM: w_next = LATCH;
            LATCH:    w_next = SEND;
            SEND:     w_next = WAIT_TX;
            WAIT_TX:  if (i_tx_done) w_next = (r_byte_cnt == LAST_BYTE) ? NEXT : SEND;
            NEXT:     w_next = (r_addr == LAST_ADDR) ? DONE : ADDR;
            DONE:     w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    // Strobes and busy are decoded from the next state so they are clean
    // flop outputs that line up exactly with the state they belong to.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_shift    <= '0;
            r_byte_cnt <= '0;
            r_tx_start <= 1'b0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_tx_start <= (w_next == SEND);
            r_done     <= (w_next == DONE);
            r_busy     <= (w_next != IDLE);
            case (r_state)
                IDLE: begin
                    if (i_start) r_addr <= '0;
                end
                LATCH: begin
                    r_shift    <= i_data_mem_debug_unit;
                    r_byte_cnt <= '0;
                end
                WAIT_TX: begin
                    if (i_tx_done) begin
                        r_shift    <= r_shift << NB_BYTE;
                        r_byte_cnt <= r_byte_cnt + 1'b1;
                    end
                end
                NEXT: begin
                    if (r_addr != LAST_ADDR) r_addr <= r_addr + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign o_addr_mem_debug_unit = r_addr;
    assign o_ctrl_addr_debug_mem = r_busy;
    assign o_ctrl_wr_debug_mem   = 1'b0;
    assign o_tx_data             = r_shift[NB_DATA-1 -: NB_BYTE];
    assign o_tx_start            = r_tx_start;
    assign o_busy                = r_busy;
    assign o_done                = r_done;

endmodule

// File: doc/mem_dump_ctrl.md
MEM_DUMP_CTRL -- requirements
Module: mem_dump_ctrl

Interface
REQ-001 The block SHALL have parameter NB_DATA, default 32, data-memory word width in bits.
REQ-002 The block SHALL have parameter NB_ADDR, default 10, data-memory debug address width in bits.
REQ-003 The block SHALL have parameter N_WORDS, default 32, number of words dumped per run, range 1..2^NB_ADDR.
REQ-004 The block SHALL have parameter NB_BYTE, default 8, transmit byte width in bits.
REQ-005 i_clock  in  1  single clock, all logic on the rising edge.
REQ-006 i_reset  in  1  synchronous, active-high reset.
REQ-007 i_start  in  1  one-cycle request to begin a dump; sampled only in IDLE.
REQ-008 i_data_mem_debug_unit  in  NB_DATA  memory read data, valid 2 cycles after the address is driven.
REQ-009 i_tx_done  in  1  one-cycle pulse from the UART transmitter marking byte sent.
REQ-010 o_addr_mem_debug_unit  out  NB_ADDR  debug read address to data memory.
REQ-011 o_ctrl_addr_debug_mem  out  1  selects the debug address into memory; high whenever not IDLE.
REQ-012 o_ctrl_wr_debug_mem  out  1  debug write enable; tied 0, the dump is read-only.
REQ-013 o_tx_data  out  NB_BYTE  byte to transmit.
REQ-014 o_tx_start  out  1  one-cycle pulse requesting transmission of o_tx_data.
REQ-015 o_busy  out  1  high in every state except IDLE.
REQ-016 o_done  out  1  one-cycle pulse when the last byte of the last word is acknowledged.

Function
REQ-017 The FSM SHALL have states IDLE, ADDR, WAIT_MEM, LATCH, SEND, WAIT_TX, NEXT, DONE.
REQ-018 IDLE: i_start=1 -> ADDR with address counter cleared to 0; otherwise remain.
REQ-019 ADDR -> WAIT_MEM -> LATCH unconditionally, one cycle each; o_addr_mem_debug_unit holds the counter throughout.
REQ-020 LATCH SHALL load i_data_mem_debug_unit into a NB_DATA shift register, clear the byte counter, and go to SEND.
REQ-021 SEND SHALL assert o_tx_start for exactly one cycle with o_tx_data = shift register MSB byte, then go to WAIT_TX.
REQ-022 WAIT_TX SHALL hold o_tx_data stable until i_tx_done=1.
REQ-023 On i_tx_done in WAIT_TX: shift register left by NB_BYTE, increment byte counter; if it was NB_DATA/NB_BYTE-1 -> NEXT, else -> SEND.
REQ-024 Bytes SHALL go out most-significant first; each word takes NB_DATA/NB_BYTE bytes (4 at default).
REQ-025 NEXT: counter = N_WORDS-1 -> DONE; else increment counter -> ADDR.
REQ-026 The address counter SHALL never wrap; the highest address driven is N_WORDS-1.
REQ-027 DONE SHALL assert o_done one cycle, then go to IDLE; o_ctrl_addr_debug_mem falls the cycle after DONE.
REQ-028 i_start outside IDLE SHALL be ignored, without queuing.
REQ-029 i_tx_done outside WAIT_TX SHALL be ignored.
REQ-030 i_start and i_tx_done simultaneous in IDLE: only i_start acts.
REQ-031 No timeout: WAIT_TX SHALL wait indefinitely for i_tx_done.
REQ-032 o_tx_start and o_done SHALL be registered outputs, free of glitches.

Reset
REQ-033 i_reset=1 at a rising edge SHALL force IDLE from any state, including mid-word or mid-byte.
REQ-034 Reset values: o_addr_mem_debug_unit=0, o_ctrl_addr_debug_mem=0, o_ctrl_wr_debug_mem=0, o_tx_data=0, o_tx_start=0, o_busy=0, o_done=0; shift register and counters 0.
REQ-035 Reset SHALL override i_start in the same cycle.
REQ-036 After reset, a new i_start SHALL restart the dump from address 0.

Verification
REQ-037 N_WORDS=2, mem[0]=0x12345678, mem[1]=0xCAFEBABE, i_tx_done 3 cycles after each o_tx_start -> bytes 12,34,56,78,CA,FE,BA,BE in order; o_done exactly once; addresses 0 then 1 only.
REQ-038 Start pulse -> o_ctrl_addr_debug_mem=1 and o_busy=1 the next cycle; o_ctrl_wr_debug_mem=0 in every cycle.
REQ-039 i_start pulsed during WAIT_TX of word 0 -> byte stream unchanged; single o_done.
REQ-040 Hold i_tx_done=0 for 100 cycles in WAIT_TX -> o_tx_data stable, no extra o_tx_start, address unchanged.
REQ-041 i_reset during byte 2 of word 1 -> next cycle all outputs at reset values; new i_start resends from address 0, byte 0x12.
REQ-042 N_WORDS=1024 (full range) -> last address 0x3FF, no wrap to 0, o_done after 4096 bytes.
